// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for loads and stores plus the misalignment check.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic        wen_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  len_i,
    input  logic [3:0]  wmask_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  lane_mask_o,
    output logic [31:0] lane_data_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  mask_wide;
    logic [31:0] rshift;
    logic [31:0] keep;
    logic        len_ok;
    logic [3:0]  end_byte;

    assign mask_wide   = {4'b0000, wmask_i} << off_i;
    assign lane_mask_o = mask_wide[3:0];
    assign lane_data_o = wdata_i << {off_i, 3'b000};

    assign rshift = rword_i >> {off_i, 3'b000};

    always_comb begin
        keep   = 32'h0;
        len_ok = 1'b0;
        case (len_i)
            LEN_B: begin keep = 32'h0000_00FF; len_ok = 1'b1; end
            LEN_H: begin keep = 32'h0000_FFFF; len_ok = 1'b1; end
            LEN_W: begin keep = 32'hFFFF_FFFF; len_ok = 1'b1; end
            default: begin keep = 32'h0; len_ok = 1'b0; end
        endcase
    end

    assign rdata_o  = rshift & keep;
    assign end_byte = {2'b00, off_i} + {1'b0, len_i};

    // Stores fault when a mask bit spills past byte 3 after shifting.
    assign misalign_o = wen_i ? (|mask_wide[7:4])
                              : (!len_ok || (end_byte > 4'd4));

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable response latency.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]   diff;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          fault;
    logic [3:0]    lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   ld_data;
    logic          misalign;
    logic          unused_bits;

    assign diff     = req_addr - BASE;
    assign idx      = diff[AW+1:2];
    assign in_range = (diff[31:AW+2] == '0);

    assign unused_bits = ^{req_wmask[7:4], diff[1:0]};

    mem_lane_align u_align (
        .wen_i       (req_wen),
        .off_i       (req_addr[1:0]),
        .len_i       (req_len),
        .wmask_i     (req_wmask[3:0]),
        .wdata_i     (req_wdata),
        .rword_i     (mem_q[idx]),
        .lane_mask_o (lane_mask),
        .lane_data_o (lane_data),
        .rdata_o     (ld_data),
        .misalign_o  (misalign)
    );

    assign fault     = !in_range || misalign;
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d   = fault;
                    rdata_d = (fault || req_wen) ? 32'h0 : ld_data;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; stores commit on the accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_wen && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem_q[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=2 (a_*) and LATENCY=1 (b_*).
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_wen;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [2:0]  a_req_len;
    logic [7:0]  a_req_wmask;
    logic        a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_wen;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [2:0]  b_req_len;
    logic [7:0]  b_req_wmask;
    logic        b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_responder #(.BASE(BASE), .DEPTH_WORDS(4096), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_wen(a_req_wen), .req_addr(a_req_addr), .req_len(a_req_len),
        .req_wdata(a_req_wdata), .req_wmask(a_req_wmask),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    mem_responder #(.BASE(BASE), .DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_wen(b_req_wen), .req_addr(b_req_addr), .req_len(b_req_len),
        .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One full transaction on the LATENCY=2 instance with resp_ready high.
    // Called #1 after a posedge while the responder is idle.
    task automatic xact(input logic wen, input logic [31:0] addr,
                        input logic [2:0] len, input logic [31:0] wd,
                        input logic [7:0] wm, output logic [31:0] rd,
                        output logic er, output int lat);
        a_req_wen   = wen;
        a_req_addr  = addr;
        a_req_len   = len;
        a_req_wdata = wd;
        a_req_wmask = wm;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        lat = 0;
        while (a_resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        rd = a_resp_rdata;
        er = a_resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_wen = 1'b0; a_req_addr = BASE;
        a_req_len = 3'd4; a_req_wdata = 32'h0; a_req_wmask = 8'h0;
        a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = BASE;
        b_req_len = 3'd4; b_req_wdata = 32'h0; b_req_wmask = 8'h0;
        b_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %0b want 0", a_resp_valid);
        end
        n_cmp++;
        if (a_resp_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err: got %0b want 0", a_resp_err);
        end
        n_cmp++;
        if (a_resp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 0", a_resp_rdata);
        end
        n_cmp++;
        if (a_req_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_hi: got %0b want 0", a_req_ready);
        end
        n_cmp++;
        if (b_resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_b_valid: got %0b want 0", b_resp_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready_lo: got %0b want 1", a_req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, BASE, 3'd4, 32'hDEAD_BEEF, 8'h0F, rd, er, lat);
        n_cmp++;
        if (er !== 1'b0 || lat != 2) begin
            n_bad++; $display("FAIL word_store: err %0b lat %0d want 0/2", er, lat);
        end
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++; $display("FAIL word_store_rdata: got %h want 0", rd);
        end
        xact(1'b0, BASE, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            n_bad++; $display("FAIL word_load: got %h/%0b want deadbeef/0", rd, er);
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++; $display("FAIL word_load_lat: got %0d want 2", lat);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, BASE, 3'd4, 32'h1122_3344, 8'h0F, rd, er, lat);
        xact(1'b1, BASE + 32'd3, 3'd1, 32'h0000_00AB, 8'h01, rd, er, lat);
        n_cmp++;
        if (er !== 1'b0) begin
            n_bad++; $display("FAIL byte_store_err: got %0b want 0", er);
        end
        xact(1'b0, BASE, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hAB22_3344) begin
            n_bad++; $display("FAIL byte_word: got %h want ab223344", rd);
        end
        xact(1'b0, BASE + 32'd3, 3'd1, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'h0000_00AB || er !== 1'b0) begin
            n_bad++; $display("FAIL byte_load_b: got %h/%0b want ab/0", rd, er);
        end
        xact(1'b0, BASE + 32'd2, 3'd2, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'h0000_AB22 || er !== 1'b0) begin
            n_bad++; $display("FAIL byte_load_h: got %h/%0b want ab22/0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_3FFC, 3'd4, 32'hCAFE_F00D, 8'h0F, rd, er, lat);
        xact(1'b0, BASE + 32'd2, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL err_misalign_ld: got %h/%0b want 0/1", rd, er);
        end
        xact(1'b1, 32'h7FFF_FFFC, 3'd4, 32'h0101_0101, 8'h0F, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL err_low_store: got %0b want 1", er);
        end
        xact(1'b0, 32'h8000_3FFC, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            n_bad++; $display("FAIL err_top_word: got %h/%0b want cafef00d/0", rd, er);
        end
        xact(1'b0, 32'h8000_4000, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL err_high_ld: got %h/%0b want 0/1", rd, er);
        end
        xact(1'b1, BASE + 32'd2, 3'd4, 32'hFFFF_FFFF, 8'h07, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL err_mask_spill: got %0b want 1", er);
        end
        xact(1'b0, BASE, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'hAB22_3344) begin
            n_bad++; $display("FAIL err_unchanged: got %h want ab223344", rd);
        end
        xact(1'b0, BASE, 3'd3, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL err_len3: got %0b want 1", er);
        end
        xact(1'b0, BASE + 32'd3, 3'd2, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++; $display("FAIL err_half_cross: got %0b want 1", er);
        end
    endtask

    task automatic test_backpressure();
        int guard;
        a_resp_ready = 1'b0;
        a_req_wen = 1'b0; a_req_addr = BASE; a_req_len = 3'd4;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        guard = 0;
        while (a_resp_valid !== 1'b1 && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        n_cmp++;
        if (guard != 2) begin
            n_bad++; $display("FAIL bp_lat: got %0d want 2", guard);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hAB22_3344
                || a_req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold%0d: valid %0b rdata %h ready %0b want 1/ab223344/0",
                         i, a_resp_valid, a_resp_rdata, a_req_ready);
            end
        end
        a_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: valid %0b ready %0b want 0/1",
                     a_resp_valid, a_req_ready);
        end
    endtask

    task automatic test_lat1();
        logic acc;
        b_req_wen = 1'b1; b_req_addr = BASE; b_req_len = 3'd4;
        b_req_wdata = 32'h1234_5678; b_req_wmask = 8'h0F;
        b_req_valid = 1'b1;
        @(posedge clk);
        #1 b_req_valid = 1'b0;
        n_cmp++;
        if (b_resp_valid !== 1'b1) begin
            n_bad++; $display("FAIL l1_store_lat: valid %0b want 1", b_resp_valid);
        end
        @(posedge clk);
        #1;
        b_req_wen = 1'b0;
        b_req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            acc = b_req_ready;
            @(posedge clk);
            #1;
            n_cmp++;
            if (acc !== ((i % 2) == 0) || b_resp_valid !== ((i % 2) == 0)) begin
                n_bad++;
                $display("FAIL l1_b2b%0d: accept %0b valid %0b want %0b",
                         i, acc, b_resp_valid, ((i % 2) == 0));
            end
            if ((i % 2) == 0) begin
                n_cmp++;
                if (b_resp_rdata !== 32'h1234_5678) begin
                    n_bad++;
                    $display("FAIL l1_rdata%0d: got %h want 12345678", i, b_resp_rdata);
                end
            end
        end
        b_req_valid = 1'b0;
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic er; int lat;
        a_req_wen = 1'b1; a_req_addr = BASE + 32'd8; a_req_len = 3'd4;
        a_req_wdata = 32'h5A5A_5A5A; a_req_wmask = 8'h0F;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (a_resp_valid !== 1'b0) begin
                n_bad++; $display("FAIL rw_valid%0d: got %0b want 0", i, a_resp_valid);
            end
            @(posedge clk);
            #1;
        end
        xact(1'b0, BASE + 32'd8, 3'd4, 32'h0, 8'h0, rd, er, lat);
        n_cmp++;
        if (rd !== 32'h5A5A_5A5A || er !== 1'b0 || lat != 2) begin
            n_bad++;
            $display("FAIL rw_load: got %h/%0b/%0d want 5a5a5a5a/0/2", rd, er, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_backpressure();
        test_lat1();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
